// File: rtl/adder_pkg.sv
// Shared types for the serial-adder stimulus path: FSM state encoding and operand pair layout.
`timescale 1ns/1ps
package adder_pkg;
  localparam int ADDER_WIDTH = 2;

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_RISE, WAIT_FALL} ser_state_e;

  typedef struct packed {
    logic [ADDER_WIDTH-1:0] a;
    logic [ADDER_WIDTH-1:0] b;
  } op_pair_t;
endpackage

// File: rtl/adder_op_fifo.sv
// Synchronous operand-pair FIFO; entries are {a, b} packed, laid out like op_pair_t.
`timescale 1ns/1ps
module adder_op_fifo
  import adder_pkg::*;
#(
  parameter int DATA_W = $bits(op_pair_t),
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/adder_stim_serializer.sv
// Buffers operand pairs and serializes them LSB-first to the serial adder, waiting for its
// en_o result strobe (rise then fall) before starting the next pair; flags missing/stuck results.
`timescale 1ns/1ps
module adder_stim_serializer
  import adder_pkg::*;
#(
  parameter int WIDTH   = ADDER_WIDTH,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             en_i,
  output logic             ina,
  output logic             inb,
  input  logic             en_o,
  output logic             busy,
  output logic             timeout_err
);
  localparam int BCW = $clog2(WIDTH + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  ser_state_e         state;
  ser_state_e         state_nxt;
  logic [BCW-1:0]     bit_cnt;
  logic [TCW-1:0]     tmo_cnt;
  logic [WIDTH-1:0]   sa;
  logic [WIDTH-1:0]   sb;
  logic [2*WIDTH-1:0] head;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               shift_en;
  logic               tmo_run;
  logic               tmo_fire;
  logic               ready_en;

  // No pass-through on full; ready_en keeps the port closed until the first edge out of reset.
  assign op_ready = ready_en && !full && !rst;
  assign push     = op_valid && op_ready;

  adder_op_fifo #(
    .DATA_W (2 * WIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data ({op_a, op_b}),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!empty) state_nxt = SHIFT;
      SHIFT:     if (bit_cnt == BCW'(WIDTH - 1)) state_nxt = WAIT_RISE;
      WAIT_RISE: if (en_o) state_nxt = WAIT_FALL;
                 else if (tmo_fire) state_nxt = IDLE;
      WAIT_FALL: if (!en_o || tmo_fire) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // tmo_fire marks the cycle in which the counter would reach TIMEOUT.
  always_comb begin
    pop      = (state == IDLE) && !empty;
    shift_en = (state == SHIFT);
    tmo_run  = (state == WAIT_RISE) || (state == WAIT_FALL);
    tmo_fire = 1'b0;
    if (tmo_run && (tmo_cnt == TCW'(TIMEOUT - 1)))
      tmo_fire = (state == WAIT_RISE) ? !en_o : en_o;
  end

  // Stage p0: control registers and registered adder-facing outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= '0;
      tmo_cnt     <= '0;
      en_i        <= 1'b0;
      ina         <= 1'b0;
      inb         <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      ready_en    <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (pop)           bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
      if (state_nxt != state) tmo_cnt <= '0;
      else if (tmo_run)       tmo_cnt <= tmo_cnt + 1'b1;
      en_i <= shift_en;
      if (shift_en) begin
        ina <= sa[0];
        inb <= sb[0];
      end
      busy <= (state_nxt != IDLE);
      if (tmo_fire) timeout_err <= 1'b1;
    end
  end

  // Stage p0: operand shift registers
  always_ff @(posedge clk) begin
    if (pop) begin
      sa <= head[2*WIDTH-1:WIDTH];
      sb <= head[WIDTH-1:0];
    end else if (shift_en) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
    end
  end
endmodule
